// File: rtl/dff_share_arbiter_pkg.sv
// Shared definitions for the dff_share_arbiter slice: FSM state encoding and
// a width helper for index/pointer/counter fields.
package dff_share_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so index fields stay legal for small N.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
//   req    : per-requester write request
//   wdata  : packed write data, requester k on [k*WIDTH +: WIDTH]
//   gnt    : one-hot (or zero) registered grant
//   q      : shared register contents
//   q_upd  : pulse in the cycle after q was written
//   owner  : index of the requester that last wrote q
//   busy   : a grant is active
interface dff_share_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    import dff_share_arbiter_pkg::*;

    localparam int unsigned OW = clog2_min1(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_upd;
    logic [OW-1:0]          owner;
    logic                   busy;

    modport master (
        output req, wdata,
        input  gnt, q, q_upd, owner, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, q, q_upd, owner, busy
    );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~excl) searched
// from ptr upwards, wrapping mod N_REQ.
//   req, excl : candidate and exclusion masks
//   ptr       : search start index
//   onehot_c  : one-hot winner (zero when none)
//   idx_c     : winner index
//   valid_c   : a winner exists
module dff_share_arbiter_rr_pick
    import dff_share_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned PW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] excl,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot_c,
    output logic [PW-1:0]    idx_c,
    output logic             valid_c
);

    logic [N_REQ-1:0] cand;
    int               j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        j        = 0;
        cand     = req & ~excl;
        for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
            j = (int'(ptr) + off) % int'(N_REQ);
            if (cand[PW'(j)]) begin
                idx_c   = PW'(j);
                valid_c = 1'b1;
            end
        end
        if (valid_c) begin
            onehot_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// A granted requester writes q on every edge it keeps req high, for at most
// MAX_HOLD consecutive writes; the grant then passes round-robin.
//   clk  : system clock
//   rest : asynchronous active-low reset
//   bus  : requester interface (slave side)
module dff_share_arbiter
    import dff_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rest,
    dff_share_arbiter_if.slave  bus
);

    localparam int unsigned PW = clog2_min1(N_REQ);
    localparam int unsigned HW = clog2_min1(MAX_HOLD + 1);

    state_t           state;
    logic [N_REQ-1:0] gnt_r;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner_r;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] q_r;
    logic             q_upd_r;
    logic             busy_r;

    logic             own_req_c;
    logic             hold_full_c;
    logic [PW-1:0]    next_idx_c;
    logic [WIDTH-1:0] own_data_c;
    logic [PW-1:0]    pick_ptr_c;
    logic [N_REQ-1:0] pick_excl_c;
    logic [N_REQ-1:0] pick_onehot_c;
    logic [PW-1:0]    pick_idx_c;
    logic             pick_valid_c;

    assign own_req_c   = |(bus.req & gnt_r);
    assign hold_full_c = (hold_cnt >= HW'(MAX_HOLD));
    assign next_idx_c  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

    // Owner data mux and picker setup; in GRANT the search starts after the
    // owner, which is excluded only when it dropped its request.
    always_comb begin
        own_data_c  = '0;
        pick_ptr_c  = rr_ptr;
        pick_excl_c = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (gnt_idx == PW'(k)) begin
                own_data_c = bus.wdata[k*WIDTH +: WIDTH];
            end
        end
        if (state == ST_GRANT) begin
            pick_ptr_c = next_idx_c;
            if (!own_req_c) begin
                pick_excl_c = gnt_r;
            end
        end
    end

    dff_share_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req      (bus.req),
        .excl     (pick_excl_c),
        .ptr      (pick_ptr_c),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .valid_c  (pick_valid_c)
    );

    // FSM, storage register and registered outputs.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state    <= ST_IDLE;
            gnt_r    <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            owner_r  <= '0;
            hold_cnt <= '0;
            q_r      <= '0;
            q_upd_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            q_upd_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid_c) begin
                        state    <= ST_GRANT;
                        gnt_r    <= pick_onehot_c;
                        gnt_idx  <= pick_idx_c;
                        hold_cnt <= HW'(1);
                        busy_r   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (own_req_c) begin
                        q_r     <= own_data_c;
                        owner_r <= gnt_idx;
                        q_upd_r <= 1'b1;
                    end
                    if (own_req_c && !hold_full_c) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else begin
                        // Release: hand over directly, or fall back to IDLE.
                        rr_ptr <= next_idx_c;
                        if (pick_valid_c) begin
                            gnt_r    <= pick_onehot_c;
                            gnt_idx  <= pick_idx_c;
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= ST_IDLE;
                            gnt_r    <= '0;
                            hold_cnt <= '0;
                            busy_r   <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.q     = q_r;
    assign bus.q_upd = q_upd_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MH = 4;

    logic clk  = 1'b0;
    logic rest = 1'b0;

    always #5 clk = ~clk;

    dff_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    dff_share_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] req;
        logic [31:0] wdata;
        logic [3:0] gnt;
        logic [7:0] q;
        logic       upd;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [3:0] g, input logic [7:0] qe,
                       input logic u, input logic [1:0] o, input logic b);
        nvec++;
        if (bus.gnt !== g || bus.q !== qe || bus.q_upd !== u ||
            bus.owner !== o || bus.busy !== b) begin
            nerr++;
            $display("FAIL %s: got gnt=%b q=%h q_upd=%b owner=%0d busy=%b, want gnt=%b q=%h q_upd=%b owner=%0d busy=%b",
                     name, bus.gnt, bus.q, bus.q_upd, bus.owner, bus.busy, g, qe, u, o, b);
        end
    endtask

    task automatic add(input string name, input bit rst, input logic [3:0] req,
                       input logic [31:0] wd, input logic [3:0] g, input logic [7:0] qe,
                       input logic u, input logic [1:0] o, input logic b);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.wdata = wd;
        v.gnt = g; v.q = qe; v.upd = u; v.owner = o; v.busy = b;
        vq.push_back(v);
    endtask

    // Reset with random inputs across edges, then release away from an edge.
    task automatic do_reset();
        rest      = 1'b0;
        bus.req   = 4'($urandom);
        bus.wdata = $urandom;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_hold", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        rest    = 1'b1;
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        chk("reset_release_idle", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] wd;
        int          wr;
        int          gi;

        bus.req   = '0;
        bus.wdata = '0;

        // Single requester 1, re-granted at hold expiry without a gap.
        wd = 32'h3344_A566;
        add("single_c1", 1'b1, 4'b0010, wd, 4'b0010, 8'h00, 1'b0, 2'd0, 1'b1);
        for (int c = 2; c <= 7; c++)
            add($sformatf("single_c%0d", c), 1'b0, 4'b0010, wd, 4'b0010, 8'hA5, 1'b1, 2'd1, 1'b1);
        add("single_drop", 1'b0, 4'b0000, wd, 4'b0000, 8'hA5, 1'b0, 2'd1, 1'b0);

        // Fairness: all four requesting, each holds MAX_HOLD writes.
        wd = 32'h1312_1110;
        add("fair_c1", 1'b1, 4'b1111, wd, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1);
        for (int c = 2; c <= 18; c++) begin
            wr = ((c - 2) / 4) % 4;
            gi = ((c - 1) / 4) % 4;
            add($sformatf("fair_c%0d", c), 1'b0, 4'b1111, wd, 4'(1 << gi),
                8'(8'h10 + wr), 1'b1, 2'(wr), 1'b1);
        end

        // Early drop by owner 0 while requester 2 waits.
        wd = 32'h002C_000A;
        add("drop_c1", 1'b1, 4'b0101, wd, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1);
        add("drop_c2", 1'b0, 4'b0101, wd, 4'b0001, 8'h0A, 1'b1, 2'd0, 1'b1);
        add("drop_c3", 1'b0, 4'b0101, wd, 4'b0001, 8'h0A, 1'b1, 2'd0, 1'b1);
        add("drop_edge", 1'b0, 4'b0100, wd, 4'b0100, 8'h0A, 1'b0, 2'd0, 1'b1);
        add("drop_next", 1'b0, 4'b0100, wd, 4'b0100, 8'h2C, 1'b1, 2'd2, 1'b1);
        add("drop_idle", 1'b0, 4'b0000, wd, 4'b0000, 8'h2C, 1'b0, 2'd2, 1'b0);

        // Wrap: pointer now at 3, requesters 3 and 0.
        wd = 32'h3D00_000A;
        add("wrap_grant3", 1'b0, 4'b1001, wd, 4'b1000, 8'h2C, 1'b0, 2'd2, 1'b1);
        for (int c = 2; c <= 4; c++)
            add($sformatf("wrap_c%0d", c), 1'b0, 4'b1001, wd, 4'b1000, 8'h3D, 1'b1, 2'd3, 1'b1);
        add("wrap_to0", 1'b0, 4'b1001, wd, 4'b0001, 8'h3D, 1'b1, 2'd3, 1'b1);
        add("wrap_w0", 1'b0, 4'b1001, wd, 4'b0001, 8'h0A, 1'b1, 2'd0, 1'b1);
        add("wrap_idle", 1'b0, 4'b0000, wd, 4'b0000, 8'h0A, 1'b0, 2'd0, 1'b0);
        add("wrap_hold", 1'b0, 4'b0000, wd, 4'b0000, 8'h0A, 1'b0, 2'd0, 1'b0);

        #2;
        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            bus.req   = vq[i].req;
            bus.wdata = vq[i].wdata;
            @(posedge clk);
            #1;
            chk(vq[i].name, vq[i].gnt, vq[i].q, vq[i].upd, vq[i].owner, vq[i].busy);
        end

        // Asynchronous reset mid-tenure, then arbitration restarts at index 0.
        do_reset();
        bus.wdata = 32'h0F5E_0000;
        bus.req   = 4'b0100;
        @(posedge clk); #1;
        chk("ar_grant2", 4'b0100, 8'h00, 1'b0, 2'd0, 1'b1);
        @(posedge clk); #1;
        chk("ar_write2", 4'b0100, 8'h5E, 1'b1, 2'd2, 1'b1);
        bus.req = 4'b0000;
        @(posedge clk); #1;
        chk("ar_idle_ptr3", 4'b0000, 8'h5E, 1'b0, 2'd2, 1'b0);
        bus.req = 4'b0100;
        @(posedge clk); #1;
        chk("ar_regrant2", 4'b0100, 8'h5E, 1'b0, 2'd2, 1'b1);
        @(posedge clk); #1;
        chk("ar_rewrite2", 4'b0100, 8'h5E, 1'b1, 2'd2, 1'b1);
        #2;
        rest = 1'b0;
        #1;
        chk("ar_async_clear", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        #2;
        rest    = 1'b1;
        bus.req = 4'b1111;
        @(posedge clk); #1;
        chk("ar_restart_idx0", 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-register stage.
- N_REQ requesters compete for write access. The block grants one requester at a time and loads that requester's data into the shared register.
- It bounds tenure to MAX_HOLD writes so that no requester starves.
- Sits between the requester blocks and the shared storage flop. The storage flop is internal to this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register and of each requester's data.
- MAX_HOLD, 4, maximum consecutive write cycles per grant (>=1).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rest  in  1  asynchronous, active-low reset; clears all state immediately when 0.
- req  in  N_REQ  request vector; bit k high means requester k wants to write.
- wdata  in  N_REQ*WIDTH  write data; requester k drives bits [k*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot (or zero) grant vector, registered.
- q  out  WIDTH  shared register contents.
- q_upd  out  1  one-cycle pulse, high in the cycle after q was written.
- owner  out  clog2(N_REQ)  index of the requester that last wrote q.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (rest=0, asynchronous): gnt=0, q=0, q_upd=0, owner=0, busy=0. Internal state: state=IDLE, rr_ptr=0, hold_cnt=0.
- States: IDLE, GRANT.
- Arbitration function: winner = first index i, searched as ptr, ptr+1, ... wrapping mod N_REQ, with req[i]=1.
- IDLE:
  - If req!=0, the next edge sets gnt=onehot(winner from rr_ptr), hold_cnt=1, busy=1, and moves to GRANT.
  - No write occurs in the arbitration cycle, so grant latency is 1 cycle from req.
  - If req=0, remain in IDLE.
- GRANT with current owner k (gnt[k]=1):
  - Write: on each edge with req[k]=1, q<=wdata[k], owner<=k, and q_upd=1 in the following cycle. Otherwise q_upd=0.
  - Continue: if req[k]=1 and hold_cnt<MAX_HOLD, keep the grant and increment hold_cnt.
  - Release: triggered when req[k]=0, or when req[k]=1 and hold_cnt==MAX_HOLD (the write still happens on that edge). On release:
    - set rr_ptr=(k+1) mod N_REQ;
    - compute winner from (k+1) mod N_REQ over current req, excluding k only when it was released by req drop;
    - if a winner exists, the grant moves directly to it (no IDLE bubble) with hold_cnt=1;
    - otherwise gnt=0, busy=0, and the state returns to IDLE.
  - Sole requester at hold expiry: k is re-granted (gnt[k] stays high, hold_cnt=1). Writes continue back-to-back with no gap.
- Grant dropped by requester: a requester dropping req mid-tenure loses the grant on the same edge. No write occurs on that edge.
- Grant width: gnt is never more than one-hot. req bits for non-granted requesters have no effect on q.
- Wrap-around: rr_ptr and index arithmetic are mod N_REQ. After owner N_REQ-1, the search begins at index 0.
- Reset mid-tenure: gnt and q clear immediately (asynchronous). After rest deasserts, the first arbitration starts from index 0.
- Throughput: a single continuous requester gets a write every cycle after the first grant cycle.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1) and a clog2 helper for the owner and pointer widths.
- One sub-module, rr_pick: a combinational round-robin priority picker taking req, ptr and an exclude mask, and returning a one-hot winner plus a valid bit.
- Keep the storage register and FSM in dff_share_arbiter.

Test Plan:
- Reset: hold rest=0 with random req/wdata, then release -> gnt=0, q=0x00, q_upd=0, busy=0. Assert rest=0 mid-grant -> outputs clear without waiting for clk.
- Single requester: req=4'b0010, wdata[1]=0xA5 held 6 cycles ->
  - gnt=0010 from cycle 1;
  - q=0xA5 from cycle 2 with q_upd high on cycles 2..6;
  - owner=1;
  - re-grant at MAX_HOLD with no gap.
- Fairness: req=4'b1111 constant, wdata[k]=0x10+k ->
  - grants 0,1,2,3,0, each held exactly 4 cycles;
  - q sequence 0x10x4, 0x11x4, 0x12x4, 0x13x4.
- Early drop: owner 0 drops req after 2 writes while req[2]=1 -> gnt switches to 0100 on the drop edge; q holds the last 0-data for one cycle, then takes wdata[2].
- Wrap: rr_ptr at 3, req=4'b1001 -> owner 3 tenure, then gnt=0001. Last requester drops -> gnt=0000, busy=0, IDLE; q holds its value.
